// File: rtl/bmp_compare_acc_pkg.sv
// Shared constants and state encoding for the bitmap compare/accumulate sequencer.
package bmp_compare_acc_pkg;
  localparam int unsigned NCOLS       = 24;
  localparam int unsigned COLW        = 64;
  localparam int unsigned NROWS       = 64;
  localparam int unsigned ROWW        = 24;
  localparam int unsigned TIMEOUT_DEF = 15;

  localparam int unsigned SCORE_W   = 11;
  localparam int unsigned MATCH_W   = 7;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned COL_IDX_W = 5;
  localparam int unsigned WAIT_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    COL_REQ,
    COL_WAIT,
    BOT_REQ,
    BOT_WAIT,
    TOP_REQ,
    TOP_WAIT,
    DONE
  } state_t;
endpackage

// File: rtl/bmp_compare_acc_if.sv
// Request/ready link between the bitmap register (master) and the compare sequencer (slave).
interface bmp_compare_acc_if;
  import bmp_compare_acc_pkg::*;

  logic            alustart;
  logic [COLW-1:0] columnin;
  logic            colready;
  logic            finalcolumn;
  logic [ROWW-1:0] botrowin;
  logic            rowbotready;
  logic [ROWW-1:0] toprowin;
  logic            rowtopready;
  logic            nextcol;
  logic            nextrowbot;
  logic            nextrowtop;

  modport master (
    output alustart, columnin, colready, finalcolumn,
           botrowin, rowbotready, toprowin, rowtopready,
    input  nextcol, nextrowbot, nextrowtop
  );

  modport slave (
    input  alustart, columnin, colready, finalcolumn,
           botrowin, rowbotready, toprowin, rowtopready,
    output nextcol, nextrowbot, nextrowtop
  );
endinterface

// File: rtl/bmp_compare_acc_popcnt64.sv
// Combinational 64-bit population count as a two-level adder tree (8 bytes, then byte sums).
module popcnt64
  import bmp_compare_acc_pkg::*;
(
  input  logic [COLW-1:0]    data_i,
  output logic [MATCH_W-1:0] count_o
);
  logic [3:0] grp [8];

  always_comb begin
    for (int g = 0; g < 8; g++) begin
      grp[g] = '0;
      for (int b = 0; b < 8; b++) begin
        grp[g] = grp[g] + {3'b000, data_i[g*8+b]};
      end
    end
    count_o = '0;
    for (int g = 0; g < 8; g++) begin
      count_o = count_o + {3'b000, grp[g]};
    end
  end
endmodule

// File: rtl/bmp_compare_acc.sv
// Pulls every column slice and scores it against the template, then scans rows
// bottom-up and top-down to find the vertical ink extent.
module bmp_compare_acc
  import bmp_compare_acc_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bmp_compare_acc_if.slave     bus,
  input  logic                 template_wr,
  input  logic [COLW-1:0]      template_in,
  output logic                 busy,
  output logic                 done,
  output logic [SCORE_W-1:0]   score,
  output logic [COL_IDX_W-1:0] best_col,
  output logic [MATCH_W-1:0]   best_match,
  output logic [IDX_W-1:0]     bot_row,
  output logic [IDX_W-1:0]     top_row,
  output logic                 blank,
  output logic                 err_timeout
);
  state_t               state_q, state_d;
  logic [COLW-1:0]      template_q, template_d;
  logic [COL_IDX_W-1:0] col_cnt_q, col_cnt_d;
  logic [IDX_W-1:0]     row_idx_q, row_idx_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [COL_IDX_W-1:0] best_col_q, best_col_d;
  logic [MATCH_W-1:0]   best_match_q, best_match_d;
  logic [IDX_W-1:0]     bot_row_q, bot_row_d, top_row_q, top_row_d;
  logic                 blank_q, blank_d, err_q, err_d;
  logic                 nextcol_q, nextcol_d, nextbot_q, nextbot_d, nexttop_q, nexttop_d;
  logic [MATCH_W-1:0]   match;
  logic                 wait_expired;

  popcnt64 u_popcnt (
    .data_i  (~(bus.columnin ^ template_q)),
    .count_o (match)
  );

  assign wait_expired = (wait_q == WAIT_W'(TIMEOUT));
  assign busy         = (state_q != IDLE) && (state_q != DONE);

  always_comb begin
    state_d      = state_q;
    template_d   = template_q;
    col_cnt_d    = col_cnt_q;
    row_idx_d    = row_idx_q;
    wait_d       = wait_q;
    score_d      = score_q;
    best_col_d   = best_col_q;
    best_match_d = best_match_q;
    bot_row_d    = bot_row_q;
    top_row_d    = top_row_q;
    blank_d      = blank_q;
    err_d        = err_q;
    nextcol_d    = 1'b0;
    nextbot_d    = 1'b0;
    nexttop_d    = 1'b0;

    if (template_wr && !busy) template_d = template_in;

    unique case (state_q)
      IDLE: begin
        if (bus.alustart) begin
          score_d      = '0;
          best_col_d   = '0;
          best_match_d = '0;
          bot_row_d    = '0;
          top_row_d    = '0;
          blank_d      = 1'b0;
          err_d        = 1'b0;
          col_cnt_d    = '0;
          state_d      = COL_REQ;
        end
      end
      COL_REQ: begin
        if (bus.finalcolumn || (col_cnt_q == COL_IDX_W'(NCOLS))) begin
          row_idx_d = '0;
          state_d   = BOT_REQ;
        end else begin
          nextcol_d = 1'b1;
          wait_d    = '0;
          state_d   = COL_WAIT;
        end
      end
      COL_WAIT: begin
        if (bus.colready) begin
          score_d = score_q + SCORE_W'(match);
          // Column 0 seeds the best; later ties keep the earlier column.
          if ((col_cnt_q == '0) || (match > best_match_q)) begin
            best_match_d = match;
            best_col_d   = col_cnt_q;
          end
          col_cnt_d = col_cnt_q + 1'b1;
          state_d   = COL_REQ;
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      BOT_REQ: begin
        nextbot_d = 1'b1;
        wait_d    = '0;
        state_d   = BOT_WAIT;
      end
      BOT_WAIT: begin
        if (bus.rowbotready) begin
          if (|bus.botrowin) begin
            bot_row_d = row_idx_q;
            row_idx_d = IDX_W'(NROWS - 1);
            state_d   = TOP_REQ;
          end else if (row_idx_q == IDX_W'(NROWS - 1)) begin
            blank_d   = 1'b1;
            bot_row_d = '0;
            top_row_d = '0;
            state_d   = DONE;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
            state_d   = BOT_REQ;
          end
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      TOP_REQ: begin
        nexttop_d = 1'b1;
        wait_d    = '0;
        state_d   = TOP_WAIT;
      end
      TOP_WAIT: begin
        // The bottom scan already proved a set row exists, so this always terminates.
        if (bus.rowtopready) begin
          if (|bus.toprowin) begin
            top_row_d = row_idx_q;
            state_d   = DONE;
          end else begin
            row_idx_d = row_idx_q - 1'b1;
            state_d   = TOP_REQ;
          end
        end else if (wait_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      template_q   <= '0;
      col_cnt_q    <= '0;
      row_idx_q    <= '0;
      wait_q       <= '0;
      score_q      <= '0;
      best_col_q   <= '0;
      best_match_q <= '0;
      bot_row_q    <= '0;
      top_row_q    <= '0;
      blank_q      <= 1'b0;
      err_q        <= 1'b0;
      nextcol_q    <= 1'b0;
      nextbot_q    <= 1'b0;
      nexttop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      template_q   <= template_d;
      col_cnt_q    <= col_cnt_d;
      row_idx_q    <= row_idx_d;
      wait_q       <= wait_d;
      score_q      <= score_d;
      best_col_q   <= best_col_d;
      best_match_q <= best_match_d;
      bot_row_q    <= bot_row_d;
      top_row_q    <= top_row_d;
      blank_q      <= blank_d;
      err_q        <= err_d;
      nextcol_q    <= nextcol_d;
      nextbot_q    <= nextbot_d;
      nexttop_q    <= nexttop_d;
    end
  end

  assign done           = (state_q == DONE);
  assign score          = score_q;
  assign best_col       = best_col_q;
  assign best_match     = best_match_q;
  assign bot_row        = bot_row_q;
  assign top_row        = top_row_q;
  assign blank          = blank_q;
  assign err_timeout    = err_q;
  assign bus.nextcol    = nextcol_q;
  assign bus.nextrowbot = nextbot_q;
  assign bus.nextrowtop = nexttop_q;
endmodule
